hazard_controller: RTL

Central stall/flush/forward sequencer for the five-stage RISC-V pipeline. It resolves RAW hazards by forwarding from M/W and inserts load-use bubbles. It flushes wrong-path instructions on taken branches and jumps. It also runs a handshake FSM that freezes the pipeline while the data memory has not acknowledged an M-stage access, with a timeout error and saturating performance counters.

---
 rtl/riscv_pipe_pkg.sv | 22 ++
 rtl/forwarding_unit.sv | 24 ++
 rtl/hazard_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: memory-handshake FSM states, forwarding
// select encodings and the result-select code that marks a load.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } memState_t;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUResultM

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // True when a producer writes a register the consumer reads; x0 never counts.
  function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass select for one Execute-stage source register.
// The Memory stage holds the younger result, so it beats Writeback.
module forwarding_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic       regWriteM,
  input  logic [4:0] rdW,
  input  logic       regWriteW,
  output logic [1:0] fwdSel
);

  // Priority compare: M first, then W, else register file.
  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && regMatch(rdM, rsE)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && regMatch(rdW, rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the five-stage pipeline. Forwarding,
// load-use and branch flush are combinational; a small FSM freezes the
// pipeline while the data memory is outstanding and latches a sticky
// timeout error. Two saturating counters track stalls and branch flushes.
module hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  memState_t         state_reg, state_next;
  logic [WAIT_W-1:0] waitCnt_reg, waitCnt_next;
  logic              memErr_reg, memErr_next;
  logic              memStall;
  logic              lwStall;

  logic [1:0][4:0]       rsE;
  logic [1:0][1:0]       fwdSel;
  logic [1:0]            cntInc;
  logic [1:0][CNT_W-1:0] perfCnt;

  // ---------------------------------------------------------------------
  // Forwarding: one compare unit per ALU operand (0 = A/rs1, 1 = B/rs2).
  // ---------------------------------------------------------------------
  assign rsE[0] = RS1_E;
  assign rsE[1] = RS2_E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      forwarding_unit u_fwd (
        .rsE       (rsE[gi]),
        .rdM       (RD_M),
        .regWriteM (RegWriteM),
        .rdW       (RD_W),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdSel[gi])
      );
    end
  endgenerate

  // Outputs are forced to the idle value while reset is held.
  assign ForwardAE = rst ? fwdSel[0] : FWD_RF;
  assign ForwardBE = rst ? fwdSel[1] : FWD_RF;

  // ---------------------------------------------------------------------
  // Load-use detection: a load in E feeding either source of D.
  // ---------------------------------------------------------------------
  // Bubble needed when the loaded register is read by the next instruction.
  always_comb begin
    lwStall = (ResultSrcE == RESULT_LOAD) &&
              (regMatch(RD_E, RS1_D) || regMatch(RD_E, RS2_D));
  end

  // ---------------------------------------------------------------------
  // Memory handshake FSM.
  // ---------------------------------------------------------------------
  // State, wait count and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= RUN;
      waitCnt_reg <= '0;
      memErr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      waitCnt_reg <= waitCnt_next;
      memErr_reg  <= memErr_next;
    end
  end

  // Next state and freeze request. An ack with no request is ignored in
  // RUN; in MEM_WAIT the request is held by the pipeline, so ack alone ends it.
  always_comb begin
    state_next   = state_reg;
    waitCnt_next = waitCnt_reg;
    memStall     = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          memStall     = 1'b1;
          state_next   = MEM_WAIT;
          waitCnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_next   = RUN;
          waitCnt_next = '0;
        end else begin
          memStall = 1'b1;
          if (waitCnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
            state_next = ERROR;
          end else begin
            waitCnt_next = waitCnt_reg + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        memStall = 1'b1;
      end
      default: begin
        state_next   = RUN;
        waitCnt_next = '0;
      end
    endcase
    memErr_next = memErr_reg | (state_next == ERROR);
  end

  assign MemErr = memErr_reg;

  // ---------------------------------------------------------------------
  // Stall / flush. A branch resolved during a freeze stays in E and its
  // flush fires in the first unfrozen cycle, so nothing is stored.
  // ---------------------------------------------------------------------
  assign StallE = rst & memStall;
  assign StallM = rst & memStall;
  assign FlushW = rst & memStall;
  assign StallF = rst & (memStall | lwStall);
  assign StallD = rst & (memStall | lwStall);
  assign FlushD = rst & PCSrcE & ~memStall;
  assign FlushE = rst & (lwStall | PCSrcE) & ~memStall;

  // ---------------------------------------------------------------------
  // Saturating performance counters: 0 = stall cycles, 1 = branch flushes.
  // ---------------------------------------------------------------------
  assign cntInc[0] = StallF;
  assign cntInc[1] = FlushE & PCSrcE;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;

      // Count qualifying cycles, holding at all-ones instead of wrapping.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (cntInc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign perfCnt[gi] = cnt_reg;
    end
  endgenerate

  assign StallCycles = perfCnt[0];
  assign FlushEvents = perfCnt[1];

endmodule
